// File: rtl/cutting_motion_ctrl.sv
// Move-command sequencer for the cutting-head stepper: linear step-period ramp,
// signed position tracking, abort/limit handling and a post-move holding-torque settle.
module cutting_motion_ctrl #(
  parameter int CNT_W      = 16,
  parameter int DIV_W      = 24,
  parameter int POS_W      = 20,
  parameter int START_DIV  = 500000,
  parameter int RAMP_STEP  = 1000,
  parameter int SETTLE_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  input  logic             limit_n,
  input  logic             pos_clr,
  output logic             motor_en,
  output logic             motor_dir,
  output logic             step_tick,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [POS_W-1:0] position,
  output logic [CNT_W-1:0] steps_left
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [DIV_W-1:0] START_V  = DIV_W'(START_DIV);
  localparam logic [DIV_W:0]   RAMP_V   = (DIV_W+1)'(RAMP_STEP);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [DIV_W-1:0]   cur_q;
  logic [DIV_W-1:0]   tgt_q;
  logic [SET_W-1:0]   settle_q;
  logic               motor_en_q;
  logic               motor_dir_q;
  logic               step_tick_q;
  logic               done_q;
  logic               fault_q;
  logic [POS_W-1:0]   position_q;
  logic [CNT_W-1:0]   steps_left_q;

  logic [DIV_W-1:0]   tgt_d;
  logic [DIV_W-1:0]   cur_start_d;
  logic [DIV_W-1:0]   cur_ramp_d;
  logic               wrap_d;
  logic [POS_W-1:0]   pos_step_d;

  // Command clamping, ramp decrement (no underflow) and divider wrap detection
  always_comb begin
    tgt_d       = (cmd_div < DIV_MIN) ? DIV_MIN : cmd_div;
    cur_start_d = (START_V > tgt_d) ? START_V : tgt_d;
    if ({1'b0, cur_q} >= ({1'b0, tgt_q} + RAMP_V)) begin
      cur_ramp_d = cur_q - RAMP_V[DIV_W-1:0];
    end else begin
      cur_ramp_d = tgt_q;
    end
    wrap_d     = (div_cnt_q >= (cur_q - DIV_W'(1)));
    pos_step_d = motor_dir_q ? POS_W'(1) : {POS_W{1'b1}};
  end

  // Sequencer state machine with registered driver outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      cur_q        <= '0;
      tgt_q        <= '0;
      settle_q     <= '0;
      motor_en_q   <= 1'b0;
      motor_dir_q  <= 1'b0;
      step_tick_q  <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      position_q   <= '0;
      steps_left_q <= '0;
    end else begin
      step_tick_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pos_clr) begin
            position_q <= '0;
          end
          if (cmd_valid) begin
            fault_q      <= 1'b0;
            motor_dir_q  <= cmd_dir;
            steps_left_q <= cmd_steps;
            tgt_q        <= tgt_d;
            cur_q        <= cur_start_d;
            div_cnt_q    <= '0;
            if (cmd_steps == '0) begin
              done_q <= 1'b1;
            end else begin
              motor_en_q <= 1'b1;
              state_q    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // A stop request suppresses a step due on the same edge
          if (abort || !limit_n) begin
            state_q    <= ST_IDLE;
            motor_en_q <= 1'b0;
            if (!limit_n) begin
              fault_q <= 1'b1;
            end
          end else if (wrap_d) begin
            div_cnt_q   <= '0;
            step_tick_q <= 1'b1;
            position_q  <= position_q + pos_step_d;
            cur_q       <= cur_ramp_d;
            if (steps_left_q != '0) begin
              steps_left_q <= steps_left_q - CNT_W'(1);
            end
            if (steps_left_q <= CNT_W'(1)) begin
              state_q  <= ST_SETTLE;
              settle_q <= '0;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q    <= ST_IDLE;
            motor_en_q <= 1'b0;
          end else if (settle_q == SET_LAST) begin
            state_q    <= ST_IDLE;
            motor_en_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          motor_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign motor_en   = motor_en_q;
  assign motor_dir  = motor_dir_q;
  assign step_tick  = step_tick_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign position   = position_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_cutting_motion_ctrl.sv
// Directed bench for cutting_motion_ctrl with small ramp/settle parameters.
module tb_cutting_motion_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [23:0] cmd_div;
  logic        abort;
  logic        limit_n;
  logic        pos_clr;
  logic        motor_en;
  logic        motor_dir;
  logic        step_tick;
  logic        busy;
  logic        done;
  logic        fault;
  logic [7:0]  position;
  logic [15:0] steps_left;

  int n_assert = 0;
  int n_fail   = 0;
  int n;
  int nt;
  int nd;

  cutting_motion_ctrl #(
    .CNT_W(16), .DIV_W(24), .POS_W(8),
    .START_DIV(10), .RAMP_STEP(3), .SETTLE_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_div(cmd_div),
    .abort(abort), .limit_n(limit_n), .pos_clr(pos_clr),
    .motor_en(motor_en), .motor_dir(motor_dir), .step_tick(step_tick),
    .busy(busy), .done(done), .fault(fault),
    .position(position), .steps_left(steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles until the next step_tick, bounded by limit
  task automatic wait_tick(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (step_tick !== 1'b1 && cyc < limit);
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (done !== 1'b1 && cyc < limit);
  endtask

  task automatic quiet(input int cyc, output int ticks, output int dones);
    ticks = 0;
    dones = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (step_tick === 1'b1) ticks++;
      if (done === 1'b1) dones++;
    end
  endtask

  task automatic accept(input logic dir, input logic [15:0] steps, input logic [23:0] div);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    cmd_div   = div;
    tick();
    cmd_valid = 1'b0;
    cmd_steps = 16'hDEAD;
    cmd_div   = 24'd0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 16'd0;
    cmd_div = 24'd0; abort = 1'b0; limit_n = 1'b1; pos_clr = 1'b0;
    #12;
    check("rst_ready", cmd_ready, 1);
    check("rst_en", motor_en, 0);
    check("rst_busy", busy, 0);
    check("rst_pos", position, 0);
    check("rst_left", steps_left, 0);
    rst_n = 1'b1;
    tick();

    // 1: normal ramped move, +4 steps, target period 4
    accept(1'b1, 16'd4, 24'd4);
    check("t1_en", motor_en, 1);
    check("t1_dir", motor_dir, 1);
    check("t1_busy", busy, 1);
    check("t1_ready", cmd_ready, 0);
    check("t1_left0", steps_left, 4);
    wait_tick(40, n); check("t1_gap1", n, 10);
    check("t1_pos1", position, 1);
    check("t1_left1", steps_left, 3);
    wait_tick(40, n); check("t1_gap2", n, 7);
    wait_tick(40, n); check("t1_gap3", n, 4);
    wait_tick(40, n); check("t1_gap4", n, 4);
    check("t1_pos4", position, 4);
    check("t1_left4", steps_left, 0);
    check("t1_en_settle", motor_en, 1);
    wait_done(20, n); check("t1_done_lat", n, 4);
    check("t1_en_off", motor_en, 0);
    check("t1_ready_done", cmd_ready, 1);
    check("t1_busy_off", busy, 0);
    quiet(15, nt, nd);
    check("t1_idle_ticks", nt, 0);
    check("t1_idle_dones", nd, 0);

    // 2: zero-step command
    accept(1'b1, 16'd0, 24'd4);
    check("t2_done", done, 1);
    check("t2_en", motor_en, 0);
    check("t2_busy", busy, 0);
    quiet(12, nt, nd);
    check("t2_ticks", nt, 0);
    check("t2_done_once", nd, 0);
    check("t2_pos", position, 4);

    // 3a: slow target above start period -> constant 20
    accept(1'b1, 16'd3, 24'd20);
    wait_tick(60, n); check("t3a_gap1", n, 20);
    wait_tick(60, n); check("t3a_gap2", n, 20);
    wait_tick(60, n); check("t3a_gap3", n, 20);
    check("t3a_pos", position, 7);
    wait_done(20, n); check("t3a_done_lat", n, 4);

    // 3b: div=0 clamps to period 2
    accept(1'b1, 16'd5, 24'd0);
    wait_tick(40, n); check("t3b_gap1", n, 10);
    wait_tick(40, n); check("t3b_gap2", n, 7);
    wait_tick(40, n); check("t3b_gap3", n, 4);
    wait_tick(40, n); check("t3b_gap4", n, 2);
    wait_tick(40, n); check("t3b_gap5", n, 2);
    check("t3b_pos", position, 12);
    wait_done(20, n); check("t3b_done_lat", n, 4);

    // 6b: pos_clr in IDLE zeroes the position
    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
    check("t6_clr_idle", position, 0);

    // 4: abort after the second step of a -5 move
    accept(1'b0, 16'd5, 24'd4);
    check("t4_dir", motor_dir, 0);
    wait_tick(40, n); check("t4_gap1", n, 10);
    wait_tick(40, n); check("t4_gap2", n, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_en", motor_en, 0);
    check("t4_busy", busy, 0);
    check("t4_ready", cmd_ready, 1);
    check("t4_left", steps_left, 3);
    check("t4_pos", position, 8'hFE);
    check("t4_done", done, 0);
    quiet(12, nt, nd);
    check("t4_no_ticks", nt, 0);
    check("t4_no_done", nd, 0);

    // 5: limit switch in RUN
    accept(1'b1, 16'd5, 24'd4);
    wait_tick(40, n); check("t5_gap1", n, 10);
    check("t5_pos1", position, 8'hFF);
    limit_n = 1'b0;
    tick();
    check("t5_fault", fault, 1);
    check("t5_busy", busy, 0);
    check("t5_en", motor_en, 0);
    limit_n = 1'b1;
    quiet(15, nt, nd);
    check("t5_no_ticks", nt, 0);
    check("t5_sticky", fault, 1);
    check("t5_pos_hold", position, 8'hFF);
    // next accept clears fault; position wraps FF -> 00
    accept(1'b1, 16'd1, 24'd4);
    check("t5_fault_clr", fault, 0);
    wait_tick(40, n); check("t5b_gap1", n, 10);
    check("t5b_wrap", position, 0);
    limit_n = 1'b0;
    wait_done(20, n); check("t5_settle_done", n, 4);
    check("t5_settle_fault", fault, 0);
    limit_n = 1'b1;

    // 6a: pos_clr ignored while busy, then async reset mid-RUN
    accept(1'b1, 16'd3, 24'd4);
    wait_tick(40, n); check("t6_gap1", n, 10);
    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
    check("t6_clr_busy", position, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", motor_en, 0);
    check("t6_rst_dir", motor_dir, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pos", position, 0);
    check("t6_rst_left", steps_left, 0);
    check("t6_rst_ready", cmd_ready, 1);
    #3;
    rst_n = 1'b1;
    quiet(15, nt, nd);
    check("t6_post_ticks", nt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
